layer1_in_feature_loader: RTL and testbench
===========================================

# layer1_in_feature_loader

Producer-side front end for the `convnn` top level: accepts the input image as a valid/ready pixel stream and serves the layer-1 input-feature read ports. It holds two ping-pong banks. One bank fills from the stream while the other is read by layer 1. It answers `convnn`'s `layer1_in_feature_addra/addrb` and `rden_a/b` with `q_a_all/q_b_all` one cycle later, and tells the system when a complete frame is resident.

## Interface
Parameters:
- ADDR_WIDTH, 12, read-address width; matches layer-1 input-feature address width
- DATA_WIDTH, 16, width of one channel sample
- CHANNELS, 3, samples packed per word; word width W = DATA_WIDTH*CHANNELS
- FRAME_WORDS, 1024, words per frame and depth of each bank; must be ≤ 2^ADDR_WIDTH

Ports:
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- s_valid  in  1  stream beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  W  one pixel; channel c in bits [c*DATA_WIDTH +: DATA_WIDTH]
- s_last  in  1  marks the final beat of a frame
- in_feature_addra, in_feature_addrb  in  ADDR_WIDTH  read addresses from layer 1
- in_feature_rden_a, in_feature_rden_b  in  1  read enables
- in_feature_wren_a, in_feature_wren_b  in  1  must stay 0; any 1 sets err_wren
- q_a_all, q_b_all  out  W  registered read data
- frame_ready  out  1  read bank holds a complete frame; drives convnn enable
- frame_release  in  1  one-cycle pulse: consumer is finished with the read bank
- err_framing  out  1  sticky: s_last position disagreed with FRAME_WORDS
- err_wren  out  1  sticky: write enable asserted on a read port
- frame_checksum  out  DATA_WIDTH  see Configuration

## Operation
- State held: two banks, each FRAME_WORDS×W; full[1:0]; wr_bank; rd_bank; wr_cnt (counts 0..FRAME_WORDS-1).
- Each bank cycles through EMPTY → FILLING → FULL → EMPTY.
  - EMPTY → FILLING: the bank becomes wr_bank while it is empty.
  - FILLING → FULL: on the closing beat.
  - FULL → EMPTY: on frame_release while the bank is rd_bank.
- Write side:
  - s_ready = !full[wr_bank].
  - A beat is accepted when s_valid && s_ready. It writes s_data to bank[wr_bank][wr_cnt], then wr_cnt increments.
  - The closing beat is the one where wr_cnt == FRAME_WORDS-1. On it: full[wr_bank] ← 1, wr_cnt ← 0, wr_bank toggles.
- Framing check, evaluated only on accepted beats:
  - s_last on a non-closing beat sets err_framing.
  - A closing beat without s_last sets err_framing.
  - The frame always closes at FRAME_WORDS beats; s_last never truncates or extends a frame.
- Read side:
  - frame_ready = full[rd_bank].
  - frame_release while frame_ready: full[rd_bank] ← 0, rd_bank toggles.
  - frame_release while !frame_ready: ignored.
- Read ports (ports a and b are independent):
  - rden high, frame_ready high, addr < FRAME_WORDS: q ← bank[rd_bank][addr].
  - rden high with addr ≥ FRAME_WORDS, or with frame_ready low: q ← 0.
  - rden low: q holds its previous value.
  - a == b addresses are legal; both ports return the same word.
- Simultaneous events:
  - Closing beat and frame_release in the same cycle are both applied. The bank being closed never equals the bank being released, because the write bank is never full while it fills.
  - Each bank is written only while FILLING and read only while FULL, so there is no read/write collision.

## Timing
- Reset values: s_ready=1, q_a_all=q_b_all=0, frame_ready=0, err_framing=0, err_wren=0, frame_checksum=0. Reset also sets full=00, wr_bank=0, rd_bank=0, wr_cnt=0.
- Reset mid-frame discards all partial and full frames; bank contents need not be cleared.
- frame_ready rises the cycle after the closing beat is accepted. It falls the cycle after an accepted frame_release, or stays high if the other bank is already full.
- Read latency: exactly 1 cycle, from rden/addr sampled at edge N to q valid after edge N.
- s_ready falls the cycle after a closing beat when the other bank is still full. It rises the cycle after the frame_release that frees that bank.
- Sustained throughput is one beat per cycle while a bank is free.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A DATA_WIDTH accumulator sums, mod 2^DATA_WIDTH, every channel sample of every accepted beat.
  - On the closing beat, frame_checksum ← accumulator + that beat's samples, and the accumulator clears.
  - frame_checksum updates the cycle after the close and holds until the next close.
- LOADER_CHECKSUM_EN undefined: no accumulator is built and frame_checksum is constant 0.

## Test plan
- Reset, then FRAME_WORDS=16 beats of data = {i,i,i} with s_last on beat 15 → frame_ready=1 the cycle after beat 15. rden_a at addr 5 returns {5,5,5} one cycle later. err_framing=0.
- Stream three frames back-to-back with no release → s_ready=0 after the second close, beats stall. Pulse frame_release → frame_ready stays 1 and rd_bank holds frame 2. s_ready=1 next cycle, and frame 3 then completes.
- Read addr 16 (≥ FRAME_WORDS), then read any address with frame_ready=0 → q=0. Drop rden → q holds the last value.
- Set s_last on beat 3, and omit it on beat 15 of the next frame → err_framing sets and stays set. Frames still close at 16 beats.
- Assert in_feature_wren_b for one cycle → err_wren=1 and stays set. Memory contents are unchanged.
- With LOADER_CHECKSUM_EN defined, a frame of beats {1,2,3} ×16 → frame_checksum=96 the cycle after the close. Without the macro → frame_checksum stays 0.

Source files
------------

// File: rtl/layer1_in_feature_loader.sv
// layer1_in_feature_loader
// Ping-pong input-feature buffer in front of convnn layer 1. A valid/ready
// pixel stream fills one bank while layer 1 reads the other through two
// independent registered read ports.
// Optional build macro: LOADER_CHECKSUM_EN adds a per-frame channel-sum
// checksum on frame_checksum; without it frame_checksum is tied to 0.
module layer1_in_feature_loader #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNELS    = 3,
  parameter int FRAME_WORDS = 1024
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH*CHANNELS-1:0] s_data,
  input  logic                           s_last,
  input  logic [ADDR_WIDTH-1:0]          in_feature_addra,
  input  logic [ADDR_WIDTH-1:0]          in_feature_addrb,
  input  logic                           in_feature_rden_a,
  input  logic                           in_feature_rden_b,
  input  logic                           in_feature_wren_a,
  input  logic                           in_feature_wren_b,
  output logic [DATA_WIDTH*CHANNELS-1:0] q_a_all,
  output logic [DATA_WIDTH*CHANNELS-1:0] q_b_all,
  output logic                           frame_ready,
  input  logic                           frame_release,
  output logic                           err_framing,
  output logic                           err_wren,
  output logic [DATA_WIDTH-1:0]          frame_checksum
);

  localparam int W  = DATA_WIDTH * CHANNELS;
  localparam int CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CW-1:0]         LAST_CNT = CW'(FRAME_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   FW_LIM   = (ADDR_WIDTH+1)'(FRAME_WORDS);

  logic [W-1:0]  mem [2][FRAME_WORDS];
  logic [1:0]    full, full_nxt;
  logic          wr_bank, rd_bank;
  logic [CW-1:0] wr_cnt;
  logic          accept, closing, release_ok;

  // two read ports handled as a small vector
  logic [1:0][ADDR_WIDTH-1:0] port_addr;
  logic [1:0]                 port_rden;
  logic [1:0][W-1:0]          port_q;

  assign s_ready     = !full[wr_bank];
  assign frame_ready = full[rd_bank];
  assign accept      = s_valid && s_ready;
  assign closing     = accept && (wr_cnt == LAST_CNT);
  assign release_ok  = frame_release && frame_ready;

  assign port_addr = {in_feature_addrb, in_feature_addra};
  assign port_rden = {in_feature_rden_b, in_feature_rden_a};
  assign q_a_all   = port_q[0];
  assign q_b_all   = port_q[1];

  // Bank occupancy: release and close may land together; they always hit
  // different banks since the filling bank is never full.
  always_comb begin
    full_nxt = full;
    if (release_ok) full_nxt[rd_bank] = 1'b0;
    if (closing)    full_nxt[wr_bank] = 1'b1;
  end

  // Stream write into the filling bank (contents are not reset).
  always_ff @(posedge clock) begin
    if (accept) mem[wr_bank][wr_cnt] <= s_data;
  end

  // Write/read bank pointers, fill counter and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      full        <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_cnt      <= '0;
      err_framing <= 1'b0;
      err_wren    <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        wr_cnt <= closing ? '0 : wr_cnt + 1'b1;
        // s_last only audits the framing; frame length is fixed
        if (s_last != closing) err_framing <= 1'b1;
      end
      if (closing)    wr_bank <= ~wr_bank;
      if (release_ok) rd_bank <= ~rd_bank;
      if (in_feature_wren_a || in_feature_wren_b) err_wren <= 1'b1;
    end
  end

  // Registered read ports: out-of-range or no frame returns 0, idle holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      port_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (port_rden[p]) begin
          if (frame_ready && ({1'b0, port_addr[p]} < FW_LIM))
            port_q[p] <= mem[rd_bank][port_addr[p][CW-1:0]];
          else
            port_q[p] <= '0;
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc, beat_sum;

  // Sum of all channel samples in the current beat.
  always_comb begin
    beat_sum = '0;
    for (int c = 0; c < CHANNELS; c++)
      beat_sum = beat_sum + s_data[c*DATA_WIDTH +: DATA_WIDTH];
  end

  // Running frame sum; published and cleared on the closing beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc            <= '0;
      frame_checksum <= '0;
    end else if (accept) begin
      if (closing) begin
        frame_checksum <= acc + beat_sum;
        acc            <= '0;
      end else begin
        acc <= acc + beat_sum;
      end
    end
  end
`else
  assign frame_checksum = '0;
`endif

endmodule

// File: tb/tb_layer1_in_feature_loader.sv
// Bench for layer1_in_feature_loader (FRAME_WORDS=16). Reference model keeps
// resident frames as a word queue (frames in arrival order) plus the partial
// frame being collected; every cycle all outputs are compared to it.
module tb_layer1_in_feature_loader;
  localparam int AW = 12, DW = 16, CH = 3, FW = 16, W = DW*CH;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 0, s_last = 0, s_ready;
  logic [W-1:0]  s_data = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic          rden_a = 0, rden_b = 0, wren_a = 0, wren_b = 0;
  logic [W-1:0]  q_a_all, q_b_all;
  logic          frame_ready, frame_release = 0, err_framing, err_wren;
  logic [DW-1:0] frame_checksum;

  layer1_in_feature_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNELS(CH),
                             .FRAME_WORDS(FW)) dut (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .in_feature_addra(addra), .in_feature_addrb(addrb),
    .in_feature_rden_a(rden_a), .in_feature_rden_b(rden_b),
    .in_feature_wren_a(wren_a), .in_feature_wren_b(wren_b),
    .q_a_all(q_a_all), .q_b_all(q_b_all), .frame_ready(frame_ready),
    .frame_release(frame_release), .err_framing(err_framing),
    .err_wren(err_wren), .frame_checksum(frame_checksum));

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  logic          rr = 0;          // randomize read ports each cycle
  logic [W-1:0]  mf[$];           // resident frames, oldest first
  logic [W-1:0]  cur[$];          // frame being collected
  logic [W-1:0]  m_qa = '0, m_qb = '0;
  logic [DW-1:0] m_acc = '0, m_cks = '0;
  logic          m_errf = 0, m_errw = 0;
  logic          last_acc;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rd_word(input logic [AW-1:0] a);
    if (mf.size() >= FW && a < FW) return mf[a];
    return '0;
  endfunction

  // one clock: update model from pre-edge inputs, then compare outputs
  task automatic step();
    int n;
    logic [DW-1:0] bs;
    if (rr) begin
      rden_a = 1'($urandom_range(0, 1)); addra = AW'($urandom_range(0, 20));
      rden_b = 1'($urandom_range(0, 1)); addrb = AW'($urandom_range(0, 20));
    end
    n = mf.size() / FW;
    last_acc = s_valid && (n < 2);
    if (reset) begin
      mf.delete(); cur.delete();
      m_qa = '0; m_qb = '0; m_acc = '0; m_cks = '0; m_errf = 0; m_errw = 0;
      last_acc = 0;
    end else begin
      if (rden_a) m_qa = rd_word(addra);
      if (rden_b) m_qb = rd_word(addrb);
      if (wren_a || wren_b) m_errw = 1;
      if (frame_release && n > 0) repeat (FW) void'(mf.pop_front());
      if (last_acc) begin
        cur.push_back(s_data);
        bs = '0;
        for (int c = 0; c < CH; c++) bs = bs + s_data[c*DW +: DW];
        m_acc = m_acc + bs;
        if (s_last != (cur.size() == FW)) m_errf = 1;
        if (cur.size() == FW) begin
          foreach (cur[i]) mf.push_back(cur[i]);
          cur.delete();
          m_cks = m_acc; m_acc = '0;
        end
      end
    end
    @(posedge clock); #1;
    chk("s_ready", W'(s_ready), W'(mf.size() / FW < 2));
    chk("frame_ready", W'(frame_ready), W'(mf.size() >= FW));
    chk("q_a", q_a_all, m_qa);
    chk("q_b", q_b_all, m_qb);
    chk("err_framing", W'(err_framing), W'(m_errf));
    chk("err_wren", W'(err_wren), W'(m_errw));
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", W'(frame_checksum), W'(m_cks));
`else
    chk("checksum", W'(frame_checksum), '0);
`endif
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l);
    logic done = 0;
    s_valid = 1; s_data = d; s_last = l;
    for (int k = 0; k < 50 && !done; k++) begin
      step();
      done = last_acc;
    end
    if (!done) begin
      total++; bad++;
      $error("FAIL accept_timeout observed=stalled expected=accepted");
    end
  endtask

  // kind 0: {i,i,i}; 1: {1,2,3}; else random. s_last at beats lp_a / lp_b.
  task automatic send_frame(input int kind, input int lp_a, input int lp_b);
    logic [W-1:0] d;
    for (int i = 0; i < FW; i++) begin
      if (kind == 0)      d = {3{16'(i)}};
      else if (kind == 1) d = {16'd3, 16'd2, 16'd1};
      else                d = W'({$urandom(), $urandom()});
      send_beat(d, (i == lp_a) || (i == lp_b));
    end
  endtask

  task automatic release_pulse();
    frame_release = 1; step(); frame_release = 0;
  endtask

  initial begin
    logic [W-1:0] held;
    // reset values
    step(); step();
    chk("rst_s_ready", W'(s_ready), 1);
    chk("rst_frame_ready", W'(frame_ready), 0);
    chk("rst_q_a", q_a_all, 0);
    chk("rst_cks", W'(frame_checksum), 0);
    reset = 0;

    // first frame {i,i,i}, read word 5
    send_frame(0, 15, -1);
    s_valid = 0; s_last = 0;
    chk("f1_ready", W'(frame_ready), 1);
    chk("f1_errf", W'(err_framing), 0);
    rden_a = 1; addra = 5; step(); rden_a = 0;
    chk("rd_a5", q_a_all, {3{16'd5}});
    rden_a = 1; rden_b = 1; addra = 9; addrb = 9; step(); rden_a = 0; rden_b = 0;
    chk("rd_same_ab", q_b_all, {3{16'd9}});

    // checksum frame {1,2,3} x16 fills the other bank
    send_frame(1, 15, -1);
    s_valid = 0; s_last = 0;
`ifdef LOADER_CHECKSUM_EN
    chk("cks96", W'(frame_checksum), 96);
`else
    chk("cks_off", W'(frame_checksum), 0);
`endif
    release_pulse(); release_pulse();
    chk("all_released", W'(frame_ready), 0);

    // three frames back to back, no release: third stalls
    rr = 1;
    send_frame(2, 15, -1);
    send_frame(2, 15, -1);
    s_valid = 1; s_last = 0; s_data = W'({$urandom(), $urandom()});
    step(); step(); step();
    chk("stall_s_ready", W'(s_ready), 0);
    release_pulse();
    chk("rel_keeps_ready", W'(frame_ready), 1);
    chk("rel_frees_bank", W'(s_ready), 1);
    send_frame(2, 15, -1);
    s_valid = 0; s_last = 0;
    rr = 0;
    step();

    // boundary reads and hold
    rden_a = 1; addra = 2; step();
    held = m_qa;
    addra = 16; step();
    chk("rd_oob16", q_a_all, 0);
    addra = AW'(4095); step();
    chk("rd_oob_max", q_a_all, 0);
    addra = 2; step(); rden_a = 0;
    step(); step();
    chk("rd_hold", q_a_all, held);
    release_pulse(); release_pulse();
    chk("empty_ready", W'(frame_ready), 0);
    rden_a = 1; addra = 2; step(); rden_a = 0;
    chk("rd_no_frame", q_a_all, 0);
    release_pulse();
    chk("rel_ignored", W'(frame_ready), 0);

    // framing errors: early s_last, then a frame with none
    send_frame(2, 3, 15);
    chk("errf_early_last", W'(err_framing), 1);
    send_frame(2, -1, -1);
    s_valid = 0; s_last = 0;
    step();
    chk("errf_sticky", W'(err_framing), 1);
    chk("errf_two_frames", W'(s_ready), 0);

    // write enable on a read port: sticky error, contents unchanged
    wren_b = 1; addrb = 4; step(); wren_b = 0;
    chk("errw_set", W'(err_wren), 1);
    for (int i = 0; i < FW; i++) begin
      rden_a = 1; addra = AW'(i); rden_b = 1; addrb = AW'(FW - 1 - i); step();
    end
    rden_a = 0; rden_b = 0;
    chk("errw_sticky", W'(err_wren), 1);

    // reset mid-frame discards everything
    release_pulse(); release_pulse();
    for (int i = 0; i < 5; i++) send_beat(W'({$urandom(), $urandom()}), 0);
    s_valid = 0;
    reset = 1; step(); reset = 0;
    chk("midrst_ready", W'(frame_ready), 0);
    chk("midrst_errf", W'(err_framing), 0);
    rr = 1;
    send_frame(2, 15, -1);
    s_valid = 0; s_last = 0;
    repeat (10) step();
    rr = 0;
    chk("midrst_frame_len", W'(frame_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
